// File: rtl/reg_file_operand_stage.sv
// Register file feeding the ALU operand latches, with write-through bypass
// and a captured ALU flag register. R0 has no storage and reads as zero.
module reg_file_operand_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              ReadEn,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              OpValid,
  input  logic              FlagWrite,
  input  logic              Zero,
  input  logic              Overflow,
  input  logic              CarryOut,
  output logic              FlagZ,
  output logic              FlagV,
  output logic              FlagC
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_r [1:NREG-1];
  logic              wr_en_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic              op_valid_r;
  logic              flag_z_r;
  logic              flag_v_r;
  logic              flag_c_r;

  // Qualify the write port; writes aimed at R0 are discarded here.
  always_comb begin
    wr_en_s = RegWrite && (WriteReg != {ADDR_W{1'b0}});
  end

  // Operand selection: R0 -> zero, a same-cycle write to the source bypasses storage.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    rd2_s = {DATA_W{1'b0}};
    for (int i = 1; i < NREG; i++) begin
      rd1_s = (ReadReg1 == ADDR_W'(i)) ? regs_r[i] : rd1_s;
      rd2_s = (ReadReg2 == ADDR_W'(i)) ? regs_r[i] : rd2_s;
    end
    if (wr_en_s && (WriteReg == ReadReg1)) begin
      rd1_s = WriteData;
    end else begin
      rd1_s = rd1_s;
    end
    if (wr_en_s && (WriteReg == ReadReg2)) begin
      rd2_s = WriteData;
    end else begin
      rd2_s = rd2_s;
    end
  end

  // Register storage for R1 and up.
  always_ff @(posedge Clock) begin
    for (int i = 1; i < NREG; i++) begin
      if (Reset) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end else if (wr_en_s && (WriteReg == ADDR_W'(i))) begin
        regs_r[i] <= WriteData;
      end
    end
  end

  // Operand latches and the one-cycle valid strobe.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      a_r        <= {DATA_W{1'b0}};
      b_r        <= {DATA_W{1'b0}};
      op_valid_r <= 1'b0;
    end else begin
      op_valid_r <= ReadEn;
      if (ReadEn) begin
        a_r <= rd1_s;
        b_r <= rd2_s;
      end
    end
  end

  // ALU flag capture, independent of the register write port.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      flag_z_r <= 1'b0;
      flag_v_r <= 1'b0;
      flag_c_r <= 1'b0;
    end else if (FlagWrite) begin
      flag_z_r <= Zero;
      flag_v_r <= Overflow;
      flag_c_r <= CarryOut;
    end
  end

  assign A       = a_r;
  assign B       = b_r;
  assign OpValid = op_valid_r;
  assign FlagZ   = flag_z_r;
  assign FlagV   = flag_v_r;
  assign FlagC   = flag_c_r;

endmodule

// File: tb/tb_reg_file_operand_stage.sv
// Scoreboard bench: read requests push expected operand pairs, a monitor
// pops and compares on every OpValid strobe.
module tb_reg_file_operand_stage;

  logic        Clock = 1'b0;
  logic        Reset, RegWrite, ReadEn, FlagWrite, Zero, Overflow, CarryOut;
  logic [1:0]  WriteReg, ReadReg1, ReadReg2;
  logic [15:0] WriteData;
  logic [15:0] A, B;
  logic        OpValid, FlagZ, FlagV, FlagC;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  reg_file_operand_stage #(.DATA_W(16), .ADDR_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .RegWrite(RegWrite), .WriteReg(WriteReg),
    .WriteData(WriteData), .ReadEn(ReadEn), .ReadReg1(ReadReg1),
    .ReadReg2(ReadReg2), .A(A), .B(B), .OpValid(OpValid),
    .FlagWrite(FlagWrite), .Zero(Zero), .Overflow(Overflow),
    .CarryOut(CarryOut), .FlagZ(FlagZ), .FlagV(FlagV), .FlagC(FlagC)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: every strobe must match the oldest queued request.
  always @(negedge Clock) begin
    if (OpValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_opvalid: got A=%h B=%h with no request pending", A, B);
      end else begin
        check("operands", {A, B}, exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    Reset = 1'b0; RegWrite = 1'b0; WriteReg = 2'd0; WriteData = 16'h0000;
    ReadEn = 1'b0; ReadReg1 = 2'd0; ReadReg2 = 2'd0;
    FlagWrite = 1'b0; Zero = 1'b0; Overflow = 1'b0; CarryOut = 1'b0;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    idle();
  endtask

  task automatic wr(input logic [1:0] r, input logic [15:0] d);
    RegWrite = 1'b1; WriteReg = r; WriteData = d;
  endtask

  task automatic rd(input logic [1:0] r1, input logic [1:0] r2, input logic [15:0] ea, input logic [15:0] eb);
    ReadEn = 1'b1; ReadReg1 = r1; ReadReg2 = r2;
    exp_q.push_back({ea, eb});
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    tick();
    Reset = 1'b1;
    tick();

    // Arbitrary contents, then reset.
    wr(2'd1, 16'h0007); FlagWrite = 1'b1; Zero = 1'b1; Overflow = 1'b1; CarryOut = 1'b1; tick();
    wr(2'd2, 16'h0009); tick();
    wr(2'd3, 16'h0001); ReadEn = 1'b1; ReadReg1 = 2'd1; ReadReg2 = 2'd2; tick();
    exp_q.push_back({16'h0007, 16'h0009});
    Reset = 1'b1; tick();
    check("reset_ab", {A, B}, 32'h0);
    check("reset_opvalid", {31'd0, OpValid}, 32'd0);
    check("reset_flags", {29'd0, FlagZ, FlagV, FlagC}, 32'd0);
    rd(2'd1, 2'd2, 16'h0000, 16'h0000); tick();
    rd(2'd3, 2'd3, 16'h0000, 16'h0000); tick();

    // Write/read and hold.
    wr(2'd1, 16'h0005); tick();
    wr(2'd2, 16'h0003); tick();
    rd(2'd1, 2'd2, 16'h0005, 16'h0003); tick();
    check("opvalid_pulse", {31'd0, OpValid}, 32'd1);
    tick();
    check("opvalid_drop", {31'd0, OpValid}, 32'd0);
    check("hold_ab", {A, B}, {16'h0005, 16'h0003});

    // R0 is not writable.
    wr(2'd0, 16'hFFFF); tick();
    rd(2'd0, 2'd0, 16'h0000, 16'h0000); tick();
    rd(2'd0, 2'd1, 16'h0000, 16'h0005); tick();
    wr(2'd0, 16'hFFFF); rd(2'd0, 2'd0, 16'h0000, 16'h0000); tick();

    // Bypass on both ports.
    wr(2'd3, 16'h000A); tick();
    wr(2'd3, 16'h0028); rd(2'd3, 2'd3, 16'h0028, 16'h0028); tick();
    rd(2'd3, 2'd1, 16'h0028, 16'h0005); tick();

    // Back-to-back requests, second one bypassing R1.
    rd(2'd2, 2'd1, 16'h0003, 16'h0005); tick();
    check("b2b_opvalid", {31'd0, OpValid}, 32'd1);
    wr(2'd1, 16'h000B); rd(2'd1, 2'd2, 16'h000B, 16'h0003); tick();
    check("b2b_opvalid2", {31'd0, OpValid}, 32'd1);
    tick();

    // Flags capture and hold.
    FlagWrite = 1'b1; Zero = 1'b1; Overflow = 1'b0; CarryOut = 1'b1; tick();
    check("flags_capture", {29'd0, FlagZ, FlagV, FlagC}, 32'b101);
    Zero = 1'b0; Overflow = 1'b1; CarryOut = 1'b0; tick();
    check("flags_hold", {29'd0, FlagZ, FlagV, FlagC}, 32'b101);
    FlagWrite = 1'b1; Zero = 1'b0; Overflow = 1'b1; CarryOut = 1'b0; wr(2'd2, 16'h004D); tick();
    check("flags_with_write", {29'd0, FlagZ, FlagV, FlagC}, 32'b010);
    rd(2'd2, 2'd2, 16'h004D, 16'h004D); tick();
    tick();

    // Reset on the same edge as a request.
    ReadEn = 1'b1; ReadReg1 = 2'd1; ReadReg2 = 2'd2; Reset = 1'b1; tick();
    check("midreset_opvalid", {31'd0, OpValid}, 32'd0);
    check("midreset_ab", {A, B}, 32'h0);
    tick();
    check("midreset_no_reappear", {31'd0, OpValid}, 32'd0);
    rd(2'd1, 2'd2, 16'h0000, 16'h0000); tick();
    tick();
    tick();

    check("queue_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_operand_stage.md
# reg_file_operand_stage

Register file and operand-latch stage directly upstream of the 16-bit ALU. It holds the CPU's general-purpose registers and registers the selected pair onto the ALU `A`/`B` inputs with a valid strobe, one cycle after a read request. It also captures the ALU's `Zero`/`Overflow`/`CarryOut` outputs into a flags register for later branch use.

## Interface
Parameters:
- `DATA_W`, 16, register and operand width (must match the ALU).
- `ADDR_W`, 2, register address width; the file holds 2^ADDR_W registers and R0 reads as constant zero.

Ports:
- `Clock`, in, 1: single clock; all state updates on its rising edge.
- `Reset`, in, 1: synchronous, active-high; has priority over every other input.
- `RegWrite`, in, 1: write enable for the write port.
- `WriteReg`, in, ADDR_W: destination register.
- `WriteData`, in, DATA_W: write data (ALU `REZ` or load data).
- `ReadEn`, in, 1: request to latch a new operand pair.
- `ReadReg1`, in, ADDR_W: source for `A`.
- `ReadReg2`, in, ADDR_W: source for `B`.
- `A`, out, DATA_W: registered operand 1 to the ALU.
- `B`, out, DATA_W: registered operand 2 to the ALU.
- `OpValid`, out, 1: `A`/`B` were refreshed by the previous cycle's `ReadEn`.
- `FlagWrite`, in, 1: capture ALU flags this cycle.
- `Zero`, in, 1: ALU zero flag.
- `Overflow`, in, 1: ALU overflow flag.
- `CarryOut`, in, 1: ALU carry-out flag.
- `FlagZ`, out, 1: registered zero flag.
- `FlagV`, out, 1: registered overflow flag.
- `FlagC`, out, 1: registered carry flag.

## Operation
- Storage: 2^ADDR_W × DATA_W registers, R1..R(2^ADDR_W−1) writable; R0 has no storage and always reads 0.
- Write: on an edge with `RegWrite`=1 and `WriteReg`≠0, `reg[WriteReg]` ← `WriteData`. A write to R0 is silently discarded.
- Operand latch: on an edge with `ReadEn`=1, `A` ← value(`ReadReg1`) and `B` ← value(`ReadReg2`). With `ReadEn`=0, `A`/`B` hold their previous values.
- value(r): 0 if r=0. Otherwise, if `RegWrite`=1 and `WriteReg`=r in the same cycle, it is `WriteData` (write-through bypass). Otherwise it is the stored `reg[r]`.
- `ReadReg1`=`ReadReg2` is legal; both operands receive the identical value.
- `OpValid` ← `ReadEn` every edge, so it is a one-cycle pulse per request and stays high for back-to-back requests.
- Flags: on an edge with `FlagWrite`=1, {`FlagZ`,`FlagV`,`FlagC`} ← {`Zero`,`Overflow`,`CarryOut`}. Otherwise they hold.
- The stage performs no arithmetic and no width change; data passes bit-exact.
- No state machine beyond the registers and the valid bit; there are no stalls and no backpressure. The consumer must take `A`/`B` in the cycle `OpValid`=1.

## Timing
- Reset (sync, edge with `Reset`=1): all registers 0, `A`=0, `B`=0, `OpValid`=0, `FlagZ`=`FlagV`=`FlagC`=0. Any write, read or flag capture in that cycle is dropped.
- Reset mid-operation: a pending `OpValid` pulse is cancelled and does not reappear after `Reset` deasserts.
- Read latency: 1 cycle. `ReadEn` at edge N gives `A`/`B`/`OpValid` valid after edge N.
- Write latency: 1 cycle to storage. A same-cycle read sees the new data through the bypass, never the stale value.
- Flag latency: 1 cycle. `FlagWrite` and `RegWrite` may be asserted together and are independent.
- Simultaneous write, and two reads of the same register: both operands bypass.

## Test plan
- Reset: pulse `Reset` after arbitrary writes. Required: all reads return 0, `A`=`B`=0, `OpValid`=0, flags=000.
- Write/read: write R1=5 and R2=3, then `ReadEn` with `ReadReg1`=1, `ReadReg2`=2. Required next cycle: `A`=5, `B`=3, `OpValid`=1, then `OpValid`=0 the following cycle.
- R0: write `WriteReg`=0 with `WriteData`=16'hFFFF, then read R0 on both ports. Required: `A`=`B`=0.
- Bypass: R3 holds 10; in the same cycle write R3=40 and `ReadEn` with both ports on R3. Required: `A`=`B`=40, and R3=40 on a later read.
- Flags: `Zero`=1, `Overflow`=0, `CarryOut`=1 with `FlagWrite`=1, then change the inputs with `FlagWrite`=0. Required: flags=101 and held.
- Reset mid-request: `ReadEn`=1 and `Reset`=1 on the same edge. Required: `OpValid`=0 and `A`=`B`=0.
